// File: rtl/timer_pkg.sv
// Shared timer parameters used by the counter, the register block and the
// compare/interrupt logic.
package timer_pkg;

  localparam int CNT_W  = 64;
  localparam int DATA_W = 32;

  // All-ones keeps a freshly reset compare from matching an early count.
  localparam logic [CNT_W-1:0] CMP_RST_VAL = {CNT_W{1'b1}};

endpackage

// File: rtl/timer_cmp_reg.sv
// Compare register: low-half staging register plus an atomic 64-bit commit
// that fires when the high half is written.
module timer_cmp_reg
  import timer_pkg::*;
#(
  parameter int               CNT_W   = timer_pkg::CNT_W,
  parameter int               DATA_W  = timer_pkg::DATA_W,
  parameter logic [CNT_W-1:0] CMP_RST = timer_pkg::CMP_RST_VAL
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cmp_wr_lo,
  input  logic              cmp_wr_hi,
  output logic [CNT_W-1:0]  cmp_val
);

  logic [DATA_W-1:0] r_lo_stage;
  logic [CNT_W-1:0]  r_cmp_val;

  // A simultaneous low/high write commits the previous staged half, since the
  // non-blocking read of r_lo_stage sees its pre-edge value.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_lo_stage <= '0;
      r_cmp_val  <= CMP_RST;
    end else begin
      if (cmp_wr_lo) r_lo_stage <= wdata;
      if (cmp_wr_hi) r_cmp_val  <= {wdata, r_lo_stage};
    end
  end

  assign cmp_val = r_cmp_val;

endmodule

// File: rtl/timer_compare_irq.sv
// Timer compare interrupt: detects the first cycle the live count equals the
// committed compare value and latches a sticky, enable-gated interrupt.
module timer_compare_irq
  import timer_pkg::*;
#(
  parameter int               CNT_W   = timer_pkg::CNT_W,
  parameter int               DATA_W  = timer_pkg::DATA_W,
  parameter logic [CNT_W-1:0] CMP_RST = timer_pkg::CMP_RST_VAL
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cmp_wr_lo,
  input  logic              cmp_wr_hi,
  input  logic              int_en_wr,
  input  logic              int_st_clr,
  output logic [CNT_W-1:0]  cmp_val,
  output logic              int_en,
  output logic              int_st,
  output logic              tim_int
);

  logic w_match_raw;
  logic w_set;
  logic r_match_q;
  logic r_int_en;
  logic r_int_st;

  timer_cmp_reg #(
    .CNT_W   (CNT_W),
    .DATA_W  (DATA_W),
    .CMP_RST (CMP_RST)
  ) u_cmp_reg (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wdata     (wdata),
    .cmp_wr_lo (cmp_wr_lo),
    .cmp_wr_hi (cmp_wr_hi),
    .cmp_val   (cmp_val)
  );

  assign w_match_raw = (count == cmp_val);
  assign w_set       = w_match_raw & ~r_match_q;

  // Only the rising edge of a match sets status, so a halted count or a clear
  // during a held match cannot re-trigger it; a set beats a same-cycle clear.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_match_q <= 1'b0;
      r_int_st  <= 1'b0;
      r_int_en  <= 1'b0;
    end else begin
      r_match_q <= w_match_raw;
      if (w_set)           r_int_st <= 1'b1;
      else if (int_st_clr) r_int_st <= 1'b0;
      if (int_en_wr)       r_int_en <= wdata[0];
    end
  end

  assign int_en  = r_int_en;
  assign int_st  = r_int_st;
  assign tim_int = r_int_st & r_int_en;

endmodule

// File: tb/tb_timer_compare_irq.sv
// Self-checking bench for timer_compare_irq: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_timer_compare_irq;
  import timer_pkg::*;

  logic              sysClk;
  logic              sysRstN;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] wdata;
  logic              cmpWrLo;
  logic              cmpWrHi;
  logic              intEnWr;
  logic              intStClr;
  logic [CNT_W-1:0]  cmpVal;
  logic              intEn;
  logic              intSt;
  logic              timInt;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state, expressed in terms of the register map.
  logic [CNT_W-1:0]  mCmp;
  logic [DATA_W-1:0] mLo;
  logic              mWasEqual;
  logic              mSt;
  logic              mEn;

  timer_compare_irq dut (
    .sys_clk    (sysClk),
    .sys_rst_n  (sysRstN),
    .count      (count),
    .wdata      (wdata),
    .cmp_wr_lo  (cmpWrLo),
    .cmp_wr_hi  (cmpWrHi),
    .int_en_wr  (intEnWr),
    .int_st_clr (intStClr),
    .cmp_val    (cmpVal),
    .int_en     (intEn),
    .int_st     (intSt),
    .tim_int    (timInt)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s differs", tag);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".cmp_val"}, cmpVal, mCmp);
    checkValue({tag, ".int_en"}, {63'd0, intEn}, {63'd0, mEn});
    checkValue({tag, ".int_st"}, {63'd0, intSt}, {63'd0, mSt});
    checkValue({tag, ".tim_int"}, {63'd0, timInt}, {63'd0, mSt & mEn});
  endtask

  // Drive one cycle of inputs, advance the model by one clock, then sample.
  task automatic applyStimulus(input logic rstN, input logic [CNT_W-1:0] cnt,
                               input logic [DATA_W-1:0] wd, input logic lo, input logic hi,
                               input logic enWr, input logic clr);
    logic isEqual;
    sysRstN  = rstN;
    count    = cnt;
    wdata    = wd;
    cmpWrLo  = lo;
    cmpWrHi  = hi;
    intEnWr  = enWr;
    intStClr = clr;
    if (!rstN) begin
      mCmp      = CMP_RST_VAL;
      mLo       = '0;
      mWasEqual = 1'b0;
      mSt       = 1'b0;
      mEn       = 1'b0;
    end else begin
      isEqual = (cnt == mCmp);
      if (isEqual && !mWasEqual) mSt = 1'b1;
      else if (clr)              mSt = 1'b0;
      mWasEqual = isEqual;
      if (hi)   mCmp = {wd, mLo};
      if (lo)   mLo  = wd;
      if (enWr) mEn  = wd[0];
    end
    @(posedge sysClk);
    #1;
  endtask

  initial begin
    logic [CNT_W-1:0] allOnes;
    logic [CNT_W-1:0] rCount;
    int               pick;
    allOnes = {CNT_W{1'b1}};

    // Reset with the count parked at all-ones, then release.
    applyStimulus(0, allOnes, 0, 0, 0, 0, 0);
    applyStimulus(0, allOnes, 0, 0, 0, 0, 0);
    checkOutput("reset");
    checkValue("reset.cmp_allones", cmpVal, allOnes);
    applyStimulus(1, allOnes, 0, 0, 0, 0, 0);
    checkOutput("first_match");
    checkValue("first_match.int_st", {63'd0, intSt}, 64'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("clear_after_reset");

    // Atomic commit of 0x10.
    applyStimulus(1, 0, 32'h10, 1, 0, 0, 0);
    checkOutput("wr_lo");
    checkValue("wr_lo.cmp_unchanged", cmpVal, allOnes);
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 0);
    checkOutput("wr_hi");
    checkValue("wr_hi.cmp_committed", cmpVal, 64'h10);
    applyStimulus(1, 0, 32'h1, 0, 0, 1, 0);
    applyStimulus(1, 64'h0F, 0, 0, 0, 0, 0);
    checkOutput("count_0f");
    applyStimulus(1, 64'h10, 0, 0, 0, 0, 0);
    checkOutput("count_10");
    checkValue("count_10.tim_int", {63'd0, timInt}, 64'd1);
    applyStimulus(1, 64'h11, 0, 0, 0, 0, 0);
    checkOutput("count_11");

    // Halted count: a clear during a held match must stick.
    applyStimulus(1, 64'h10, 0, 0, 0, 0, 0);
    applyStimulus(1, 64'h10, 0, 0, 0, 0, 1);
    checkOutput("halt_clr");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 64'h10, 0, 0, 0, 0, 0);
      checkValue("halt_hold.int_st", {63'd0, intSt}, 64'd0);
    end
    applyStimulus(1, 64'h11, 0, 0, 0, 0, 0);
    applyStimulus(1, 64'h10, 0, 0, 0, 0, 0);
    checkOutput("halt_return");
    checkValue("halt_return.int_st", {63'd0, intSt}, 64'd1);

    // Set and clear in the same cycle: set wins.
    applyStimulus(1, 64'h11, 0, 0, 0, 0, 1);
    checkOutput("pre_collision");
    applyStimulus(1, 64'h10, 0, 0, 0, 0, 1);
    checkOutput("collision");
    checkValue("collision.int_st", {63'd0, intSt}, 64'd1);

    // Enable gating.
    applyStimulus(1, 64'h11, 32'h0, 0, 0, 1, 1);
    applyStimulus(1, 64'h10, 0, 0, 0, 0, 0);
    checkOutput("gated");
    checkValue("gated.tim_int", {63'd0, timInt}, 64'd0);
    applyStimulus(1, 64'h11, 32'h1, 0, 0, 1, 0);
    checkOutput("ungated");
    checkValue("ungated.tim_int", {63'd0, timInt}, 64'd1);

    // Reset mid-operation discards the staged low half.
    applyStimulus(1, 64'h11, 32'h5, 1, 0, 0, 0);
    applyStimulus(0, 64'h11, 0, 0, 0, 0, 0);
    checkOutput("mid_reset");
    applyStimulus(1, 64'h11, 32'h0, 0, 1, 0, 0);
    checkOutput("mid_reset_commit");
    checkValue("mid_reset_commit.cmp", cmpVal, 64'h0);
    checkValue("mid_reset_commit.int_st", {63'd0, intSt}, 64'd0);

    // Randomized traffic biased toward counts near the compare value.
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4)      rCount = mCmp;
      else if (pick < 6) rCount = mCmp + 64'd1;
      else if (pick < 8) rCount = mCmp - 64'd1;
      else               rCount = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 49) != 0), rCount, $urandom_range(0, 3),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      checkOutput("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
